apb_requester: RTL

//  Synthesisable APB4 requester; replaces the behavioural bridge as the traffic source in the APB subsystem.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_addr_decoder.sv | 31 +++
 rtl/apb_requester.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, pprot bit positions and the
// data-width alignment helper used by the address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_req_state_e;

  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

  // Low address bits that must be zero for an access of the full bus width.
  function automatic int unsigned align_mask(input int unsigned data_width);
    return (data_width / 8) - 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decode: completer index from the top address bits,
// one-hot select, and an error for out-of-range index or unaligned address.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  localparam int SEL_BITS  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [SEL_BITS-1:0]   o_idx,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_decode_err
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(align_mask(DATA_WIDTH));

  logic w_unaligned;
  logic w_out_of_range;

  assign o_idx          = i_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_unaligned    = |(i_addr & ALIGN_MASK);
  assign w_out_of_range = (int'(o_idx) >= NUM_SLAVES);
  assign o_decode_err   = w_unaligned || w_out_of_range;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign o_sel[gi] = !o_decode_err && (o_idx == SEL_BITS'(gi));
  end

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one command at a time over a valid/ready channel, SETUP/ACCESS
// transfer to the decoded completer, response with decode/slave/timeout errors.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SEL_BITS      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [STRB_WIDTH-1:0]            cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [STRB_WIDTH-1:0]            pstrb,
  output logic [2:0]                       pprot,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST =
    CNT_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_req_state_e         r_state;
  logic                   r_cmd_ready;
  logic [NUM_SLAVES-1:0]  r_psel;
  logic                   r_penable;
  logic [ADDR_WIDTH-1:0]  r_paddr;
  logic                   r_pwrite;
  logic [DATA_WIDTH-1:0]  r_pwdata;
  logic [STRB_WIDTH-1:0]  r_pstrb;
  logic [2:0]             r_pprot;
  logic [SEL_BITS-1:0]    r_idx;
  logic [CNT_BITS-1:0]    r_wait_cnt;
  logic                   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_rdata;
  logic                   r_rsp_err;
  logic                   r_rsp_timeout;

  logic [SEL_BITS-1:0]    w_idx;
  logic [NUM_SLAVES-1:0]  w_sel;
  logic                   w_decode_err;
  logic [DATA_WIDTH-1:0]  w_prdata_arr [NUM_SLAVES];
  logic                   w_sel_ready;
  logic                   w_sel_slverr;

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decoder (
    .i_addr       (cmd_addr),
    .o_idx        (w_idx),
    .o_sel        (w_sel),
    .o_decode_err (w_decode_err)
  );

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_prdata
    assign w_prdata_arr[gi] = prdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only the latched target's completer signals are ever looked at.
  assign w_sel_ready  = pready[r_idx];
  assign w_sel_slverr = pslverr[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_psel        <= '0;
      r_penable     <= 1'b0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_idx         <= '0;
      r_wait_cnt    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_cmd_ready) begin
            r_cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            if (w_decode_err) begin
              r_state       <= RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_rsp_rdata   <= '0;
            end else begin
              r_state  <= SETUP;
              r_psel   <= w_sel;
              r_idx    <= w_idx;
              r_paddr  <= cmd_addr;
              r_pwrite <= cmd_write;
              r_pwdata <= cmd_write ? cmd_wdata : '0;
              r_pstrb  <= cmd_write ? cmd_strb : '0;
              r_pprot  <= cmd_prot;
            end
          end
        end
        SETUP: begin
          r_state    <= ACCESS;
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
        end
        ACCESS: begin
          // pready is tested first so a completion on the timeout edge is normal.
          if (w_sel_ready) begin
            r_state       <= RESP;
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= w_sel_slverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= (!r_pwrite && !w_sel_slverr) ? w_prdata_arr[r_idx] : '0;
          end else if ((TIMEOUT_CYCLES != 0) && (r_wait_cnt == CNT_LAST)) begin
            r_state       <= RESP;
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;

endmodule
